// File: rtl/lbus_arbiter_if.sv
// Bundle of the two request ports and the shared slave port of the local-bus
// arbiter.
//
// Handshake: a master raises mN_req with we/addr/wdata/wstrb stable. The request
// is sampled only while the arbiter is idle. Once the arbiter has granted and
// latched a request, the master may drop req. The transfer ends with a
// single-cycle mN_ack, with mN_err and mN_rdata valid in that same cycle. On the
// slave side, s_ren/s_wen is a single-cycle strobe. The slave then answers with
// s_rvalid (read) or s_wready (write). The arbiter accepts only the matching type
// of answer, and only while the transfer is outstanding.
`timescale 1ns/1ps
interface lbus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic [3:0]  m0_wstrb;
    logic [3:0]  m1_wstrb;
    logic        m0_ack;
    logic        m1_ack;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wen;
    logic        s_ren;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        s_wready;
    logic        busy;

    // Environment view: the two requesting masters plus the slave device.
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_wstrb, m1_wstrb,
               s_rdata, s_rvalid, s_wready,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               s_addr, s_wdata, s_wstrb, s_wen, s_ren, busy
    );

    // Arbiter view: serves the masters, drives the slave.
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_wstrb, m1_wstrb,
               s_rdata, s_rvalid, s_wready,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               s_addr, s_wdata, s_wstrb, s_wen, s_ren, busy
    );
endinterface

// File: rtl/lbus_arbiter.sv
// Two-master round-robin arbiter for a single local-bus slave. It runs one
// transfer at a time: IDLE -> ISSUE -> (WAIT) -> DONE. A transfer that gets no
// answer within TIMEOUT wait cycles completes with an error.
`timescale 1ns/1ps
module lbus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    lbus_arbiter_if.slave bus,
    output logic [1:0]    state_o
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;      // 0 = m0, 1 = m1 owns the current transfer
    logic        last_q, last_d;    // master granted most recently
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        rsp_ok;
    logic        finish;
    logic [31:0] fin_data;
    logic        active;

    // Only the answer type that matches the outstanding transfer counts.
    assign rsp_ok = we_q ? bus.s_wready : bus.s_rvalid;

    // Next-state: arbitration, response/timeout handling, read-data capture.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        finish   = 1'b0;
        fin_data = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // On a tie the master that was not served last wins.
                    if (bus.m0_req && bus.m1_req) gnt_d = ~last_q;
                    else                          gnt_d = bus.m1_req;
                    we_d    = gnt_d ? bus.m1_we    : bus.m0_we;
                    addr_d  = gnt_d ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = gnt_d ? bus.m1_wdata : bus.m0_wdata;
                    wstrb_d = gnt_d ? bus.m1_wstrb : bus.m0_wstrb;
                    cnt_d   = 8'h0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (rsp_ok) begin
                    finish   = 1'b1;
                    err_d    = 1'b0;
                    fin_data = we_q ? 32'h0 : bus.s_rdata;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the final counted cycle still beats the timeout.
                if (rsp_ok) begin
                    finish   = 1'b1;
                    err_d    = 1'b0;
                    fin_data = we_q ? 32'h0 : bus.s_rdata;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        finish   = 1'b1;
                        err_d    = 1'b1;
                        fin_data = 32'h0;
                    end
                end
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (finish) begin
            state_d = DONE;
            if (gnt_q) rdata1_d = fin_data;
            else       rdata0_d = fin_data;
        end
    end

    // State and datapath registers; reset discards any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            cnt_q    <= 8'h0;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decoded from the registered state.
    // The slave bus is quiet (all zero) except while a transfer is outstanding.
    assign active       = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.busy     = (state_q != IDLE);
    assign bus.s_ren    = (state_q == ISSUE) && !we_q;
    assign bus.s_wen    = (state_q == ISSUE) && we_q;
    assign bus.s_addr   = active ? addr_q : 32'h0;
    assign bus.s_wdata  = active ? wdata_q : 32'h0;
    assign bus.s_wstrb  = (active && we_q) ? wstrb_q : 4'h0;
    assign bus.m0_ack   = (state_q == DONE) && !gnt_q;
    assign bus.m1_ack   = (state_q == DONE) && gnt_q;
    assign bus.m0_err   = bus.m0_ack && err_q;
    assign bus.m1_err   = bus.m1_ack && err_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_lbus_arbiter.sv
// Bench for lbus_arbiter. A transaction-timeline model predicts every output on
// every cycle. Masters and the slave are driven from that model. Short directed
// scenarios pin the exact latencies with literal values.
`timescale 1ns/1ps
module tb_lbus_arbiter;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;   // response cycle offset from the strobe; > TIMEOUT = never
        logic [31:0] rdv;     // read data the slave returns
    } op_t;

    logic       clk;
    logic       reset_n;
    logic [1:0] state_o;

    lbus_arbiter_if bus ();

    lbus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int cur_c;
    bit chk_en;

    // ---------------- model state ----------------
    bit          tx_active;
    int          tx_m;
    int          t_issue;
    int          t_done;
    int          resp_cyc;
    bit          tx_err;
    op_t         tx_op;
    logic [31:0] tx_rdata;
    int          last_gnt;
    logic [31:0] rd_hold [2];
    bit          m_pend [2];
    bit          m_drop [2];
    op_t         m_op [2];
    op_t         dq0[$];
    op_t         dq1[$];
    bit          auto_gen;
    bit          drop_en;

    logic        exp_busy, exp_sren, exp_swen;
    logic [31:0] exp_saddr, exp_swdata;
    logic [3:0]  exp_swstrb;
    logic        exp_ack0, exp_ack1, exp_err0, exp_err1;
    logic [31:0] exp_rdata0, exp_rdata1;

    // ---------------- observation logs ----------------
    int          ack_m_q[$];
    int          ack_c_q[$];
    bit          ack_e_q[$];
    logic [31:0] ack_d_q[$];
    logic [1:0]  exp_q[$];
    int          strobe_cnt;
    int          strobe_cyc;
    int          last_busy_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cur_c, act, exp);
        end
    endtask

    function automatic op_t mk_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, input int delay, input logic [31:0] rdv);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata; o.wstrb = wstrb; o.delay = delay; o.rdv = rdv;
        return o;
    endfunction

    function automatic op_t rand_op();
        int d;
        if ($urandom_range(0, 9) < 7) d = int'($urandom_range(0, 3));
        else                          d = int'($urandom_range(0, TIMEOUT + 2));
        return mk_op(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                     4'($urandom_range(0, 15)), d, $urandom());
    endfunction

    task automatic drive_quiet();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        bus.m0_we = 1'b0; bus.m1_we = 1'b0;
        bus.m0_addr = 32'h0; bus.m1_addr = 32'h0;
        bus.m0_wdata = 32'h0; bus.m1_wdata = 32'h0;
        bus.m0_wstrb = 4'h0; bus.m1_wstrb = 4'h0;
        bus.s_rdata = 32'h0; bus.s_rvalid = 1'b0; bus.s_wready = 1'b0;
    endtask

    task automatic model_reset();
        tx_active = 1'b0; last_gnt = 1; tx_m = 0;
        rd_hold[0] = 32'h0; rd_hold[1] = 32'h0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 1'b0; m_drop[m] = 1'b0;
            m_op[m] = mk_op(1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        end
        tx_op = m_op[0];
        exp_busy = 1'b0; exp_sren = 1'b0; exp_swen = 1'b0;
        exp_saddr = 32'h0; exp_swdata = 32'h0; exp_swstrb = 4'h0;
        exp_ack0 = 1'b0; exp_ack1 = 1'b0; exp_err0 = 1'b0; exp_err1 = 1'b0;
        exp_rdata0 = 32'h0; exp_rdata1 = 32'h0;
        ack_m_q.delete(); ack_c_q.delete(); ack_e_q.delete(); ack_d_q.delete();
        strobe_cnt = 0; strobe_cyc = -1; last_busy_cyc = -1;
        cyc = 0; cur_c = -1;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_busy",   32'(bus.busy),   32'h0);
        chk("rst_state",  32'(state_o),    32'h0);
        chk("rst_ack0",   32'(bus.m0_ack), 32'h0);
        chk("rst_ack1",   32'(bus.m1_ack), 32'h0);
        chk("rst_err0",   32'(bus.m0_err), 32'h0);
        chk("rst_err1",   32'(bus.m1_err), 32'h0);
        chk("rst_sren",   32'(bus.s_ren),  32'h0);
        chk("rst_swen",   32'(bus.s_wen),  32'h0);
        chk("rst_saddr",  bus.s_addr,      32'h0);
        chk("rst_swdata", bus.s_wdata,     32'h0);
        chk("rst_swstrb", 32'(bus.s_wstrb), 32'h0);
        chk("rst_rdata0", bus.m0_rdata,    32'h0);
        chk("rst_rdata1", bus.m1_rdata,    32'h0);
        drive_quiet();
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        reset_n = 1'b1;
        chk_en  = 1'b1;
    endtask

    // ---------------- driver + model: one clock cycle ----------------
    task automatic step();
        int          c;
        int          g;
        bit          idle_now, iss, wt, dn, r0, r1, right, wrong;
        logic [31:0] fin;
        logic [31:0] sdata;
        @(posedge clk);
        #1;
        c = cyc;
        cur_c = c;
        idle_now = !tx_active;
        iss = tx_active && (c == t_issue);
        wt  = tx_active && (c > t_issue) && (c < t_done);
        dn  = tx_active && (c == t_done);

        // expected outputs for this cycle
        fin = (!tx_op.we && !tx_err) ? tx_rdata : 32'h0;
        if (dn) rd_hold[tx_m] = fin;
        exp_busy   = tx_active;
        exp_sren   = iss && !tx_op.we;
        exp_swen   = iss && tx_op.we;
        exp_saddr  = (iss || wt) ? tx_op.addr : 32'h0;
        exp_swdata = (iss || wt) ? tx_op.wdata : 32'h0;
        exp_swstrb = ((iss || wt) && tx_op.we) ? tx_op.wstrb : 4'h0;
        exp_ack0   = dn && (tx_m == 0);
        exp_ack1   = dn && (tx_m == 1);
        exp_err0   = exp_ack0 && tx_err;
        exp_err1   = exp_ack1 && tx_err;
        exp_rdata0 = rd_hold[0];
        exp_rdata1 = rd_hold[1];

        // the acked master is free again
        if (dn) begin
            last_gnt = tx_m;
            m_pend[tx_m] = 1'b0;
            m_drop[tx_m] = 1'b0;
            tx_active = 1'b0;
        end

        // masters: pick up directed ops first, else random traffic
        for (int m = 0; m < 2; m++) begin
            if (!m_pend[m]) begin
                if (m == 0 && dq0.size() > 0) begin
                    m_op[0] = dq0.pop_front(); m_pend[0] = 1'b1;
                end else if (m == 1 && dq1.size() > 0) begin
                    m_op[1] = dq1.pop_front(); m_pend[1] = 1'b1;
                end else if (auto_gen && $urandom_range(0, 3) == 0) begin
                    m_op[m] = rand_op(); m_pend[m] = 1'b1;
                end
            end
            if (drop_en && tx_active && tx_m == m && c >= t_issue && !m_drop[m] &&
                $urandom_range(0, 7) == 0)
                m_drop[m] = 1'b1;
        end
        r0 = m_pend[0] && !m_drop[0];
        r1 = m_pend[1] && !m_drop[1];
        bus.m0_req = r0;          bus.m1_req = r1;
        bus.m0_we = m_op[0].we;   bus.m1_we = m_op[1].we;
        bus.m0_addr = m_op[0].addr;   bus.m1_addr = m_op[1].addr;
        bus.m0_wdata = m_op[0].wdata; bus.m1_wdata = m_op[1].wdata;
        bus.m0_wstrb = m_op[0].wstrb; bus.m1_wstrb = m_op[1].wstrb;

        // round-robin grant of an idle cycle's requests
        if (idle_now && (r0 || r1)) begin
            if (r0 && r1) g = 1 - last_gnt;
            else          g = r0 ? 0 : 1;
            tx_active = 1'b1;
            tx_m = g;
            tx_op = m_op[g];
            t_issue = c + 1;
            tx_rdata = 32'h0;
            if (tx_op.delay <= TIMEOUT) begin
                resp_cyc = t_issue + tx_op.delay;
                t_done = resp_cyc + 1;
                tx_err = 1'b0;
            end else begin
                resp_cyc = -1;
                t_done = t_issue + TIMEOUT + 1;
                tx_err = 1'b1;
            end
        end

        // slave: exactly one matching answer inside the window, noise elsewhere
        sdata = $urandom();
        if (tx_active && c >= t_issue && c < t_done) begin
            right = (c == resp_cyc);
            wrong = 1'($urandom_range(0, 1));
            if (right && !tx_op.we) begin
                sdata = tx_op.rdv;
                tx_rdata = tx_op.rdv;
            end
            bus.s_rvalid = tx_op.we ? wrong : right;
            bus.s_wready = tx_op.we ? right : wrong;
        end else begin
            bus.s_rvalid = 1'($urandom_range(0, 1));
            bus.s_wready = 1'($urandom_range(0, 1));
        end
        bus.s_rdata = sdata;
        cyc++;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",   32'(bus.busy),    32'(exp_busy));
            chk("s_ren",  32'(bus.s_ren),   32'(exp_sren));
            chk("s_wen",  32'(bus.s_wen),   32'(exp_swen));
            chk("s_addr", bus.s_addr,       exp_saddr);
            chk("s_wdata", bus.s_wdata,     exp_swdata);
            chk("s_wstrb", 32'(bus.s_wstrb), 32'(exp_swstrb));
            chk("m0_ack", 32'(bus.m0_ack),  32'(exp_ack0));
            chk("m1_ack", 32'(bus.m1_ack),  32'(exp_ack1));
            chk("m0_err", 32'(bus.m0_err),  32'(exp_err0));
            chk("m1_err", 32'(bus.m1_err),  32'(exp_err1));
            chk("m0_rdata", bus.m0_rdata,   exp_rdata0);
            chk("m1_rdata", bus.m1_rdata,   exp_rdata1);
            if (bus.m0_ack) begin
                ack_m_q.push_back(0); ack_c_q.push_back(cur_c);
                ack_e_q.push_back(bus.m0_err); ack_d_q.push_back(bus.m0_rdata);
            end
            if (bus.m1_ack) begin
                ack_m_q.push_back(1); ack_c_q.push_back(cur_c);
                ack_e_q.push_back(bus.m1_err); ack_d_q.push_back(bus.m1_rdata);
            end
            if (bus.s_ren || bus.s_wen) begin
                strobe_cnt++;
                strobe_cyc = cur_c;
            end
            if (bus.busy) last_busy_cyc = cur_c;
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        reset_n = 1'b1;
        chk_en = 1'b0;
        auto_gen = 1'b0;
        drop_en = 1'b0;
        drive_quiet();
        model_reset();

        // minimum-latency read by m0
        do_reset();
        dq0.push_back(mk_op(1'b0, 32'h1000_0004, 32'h0, 4'hF, 0, 32'hA5A5_0001));
        repeat (5) step();
        chk("t1_ack_count", 32'(ack_m_q.size()), 32'd1);
        chk("t1_strobe_count", 32'(strobe_cnt), 32'd1);
        chk("t1_strobe_cycle", 32'(strobe_cyc), 32'd1);
        if (ack_m_q.size() > 0) begin
            chk("t1_ack_master", 32'(ack_m_q[0]), 32'd0);
            chk("t1_ack_cycle",  32'(ack_c_q[0]), 32'd2);
            chk("t1_err",        32'(ack_e_q[0]), 32'd0);
            chk("t1_rdata",      ack_d_q[0],      32'hA5A5_0001);
        end

        // both masters held: alternate grants, 4-cycle period with the answer one cycle after the strobe
        do_reset();
        dq0.push_back(mk_op(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1, 32'h1111_0000));
        dq0.push_back(mk_op(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'h1111_0001));
        dq1.push_back(mk_op(1'b1, 32'h0000_0200, 32'hCAFE_0000, 4'hF, 1, 32'h0));
        dq1.push_back(mk_op(1'b1, 32'h0000_0204, 32'hCAFE_0001, 4'h5, 1, 32'h0));
        exp_q.delete();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
        repeat (18) step();
        chk("t2_ack_count", 32'(ack_m_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_m_q.size()) begin
                chk("t2_grant_order", 32'(ack_m_q[i]), 32'(exp_q[i]));
                chk("t2_ack_cycle",   32'(ack_c_q[i]), 32'(3 + 4 * i));
            end
        end

        // m1 write that never gets an answer
        do_reset();
        dq1.push_back(mk_op(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 4'h3, NEVER, 32'h0));
        repeat (21) step();
        chk("t3_ack_count", 32'(ack_m_q.size()), 32'd1);
        chk("t3_strobe_count", 32'(strobe_cnt), 32'd1);
        chk("t3_strobe_cycle", 32'(strobe_cyc), 32'd1);
        chk("t3_busy_last", 32'(last_busy_cyc), 32'd17);
        if (ack_m_q.size() > 0) begin
            chk("t3_ack_master", 32'(ack_m_q[0]), 32'd1);
            chk("t3_ack_cycle",  32'(ack_c_q[0]), 32'd17);
            chk("t3_err",        32'(ack_e_q[0]), 32'd1);
            chk("t3_rdata",      ack_d_q[0],      32'h0);
        end

        // answer in the last counted wait cycle beats the timeout
        do_reset();
        dq0.push_back(mk_op(1'b0, 32'h3000_0010, 32'h0, 4'h0, TIMEOUT, 32'h1357_9BDF));
        repeat (21) step();
        chk("t4_ack_count", 32'(ack_m_q.size()), 32'd1);
        if (ack_m_q.size() > 0) begin
            chk("t4_ack_cycle", 32'(ack_c_q[0]), 32'd17);
            chk("t4_err",       32'(ack_e_q[0]), 32'd0);
            chk("t4_rdata",     ack_d_q[0],      32'h1357_9BDF);
        end

        // reset in WAIT: no ack, then m0 wins the first tie
        do_reset();
        dq1.push_back(mk_op(1'b0, 32'h4000_0000, 32'h0, 4'h0, NEVER, 32'h0));
        repeat (6) step();
        chk("t5_no_ack_before_reset", 32'(ack_m_q.size()), 32'd0);
        do_reset();
        dq0.push_back(mk_op(1'b0, 32'h5000_0000, 32'h0, 4'h0, 0, 32'h0BAD_F00D));
        dq1.push_back(mk_op(1'b1, 32'h5000_0004, 32'h0000_0042, 4'h1, 0, 32'h0));
        repeat (8) step();
        chk("t5_ack_count", 32'(ack_m_q.size()), 32'd2);
        if (ack_m_q.size() > 1) begin
            chk("t5_first_master",  32'(ack_m_q[0]), 32'd0);
            chk("t5_first_cycle",   32'(ack_c_q[0]), 32'd2);
            chk("t5_second_master", 32'(ack_m_q[1]), 32'd1);
            chk("t5_second_cycle",  32'(ack_c_q[1]), 32'd5);
        end

        // random traffic with request drops and bus noise
        do_reset();
        auto_gen = 1'b1;
        drop_en = 1'b1;
        repeat (3000) step();
        auto_gen = 1'b0;
        drop_en = 1'b0;
        repeat (TIMEOUT + 6) step();
        chk("rand_acks_seen", 32'(ack_m_q.size() > 100), 32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
